// File: rtl/draw_pkg.sv
// Shared constants, draw_state codes and rectangle descriptor for the Pong draw engine.
// Also holds the screen wrap-around helpers used when clipping is disabled.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int LEFT_X   = 4;
    localparam int RIGHT_X  = 154;
    localparam int PADDLE_W = 2;

    localparam logic [2:0] COLOUR_BLACK  = 3'b000;
    localparam logic [2:0] COLOUR_WHITE  = 3'b111;
    localparam logic [2:0] COLOUR_YELLOW = 3'b110;

    typedef enum logic [1:0] {
        DRAW_BLACK = 2'b00,
        DRAW_LEFT  = 2'b01,
        DRAW_BALL  = 2'b10,
        DRAW_RIGHT = 2'b11
    } draw_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWEEP,
        ST_FIN
    } draw_state_e;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] colour;
    } rect_t;

    // Origin + offset never exceeds 3*SCREEN_W, so two conditional subtracts suffice.
    function automatic logic [7:0] wrap_x(input logic [8:0] v);
        logic [8:0] r;
        if (v >= 9'(2 * SCREEN_W))  r = v - 9'(2 * SCREEN_W);
        else if (v >= 9'(SCREEN_W)) r = v - 9'(SCREEN_W);
        else                        r = v;
        return r[7:0];
    endfunction

    function automatic logic [6:0] wrap_y(input logic [7:0] v);
        logic [7:0] r;
        if (v >= 8'(2 * SCREEN_H))  r = v - 8'(2 * SCREEN_H);
        else if (v >= 8'(SCREEN_H)) r = v - 8'(SCREEN_H);
        else                        r = v;
        return r[6:0];
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Width x height raster counter pair: x offset runs fastest, then y.
// Offsets are exported as next-state values so the caller can register pixels in step.
module rect_scanner (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [7:0] w_i,
    input  logic [6:0] h_i,
    output logic [7:0] off_x_o,
    output logic [6:0] off_y_o,
    output logic       last_o
);

    logic [7:0] cx_q, cx_d, w_q, w_d;
    logic [6:0] cy_q, cy_d, h_q, h_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        w_d  = w_q;
        h_d  = h_q;
        if (load_i) begin
            cx_d = '0;
            cy_d = '0;
            w_d  = w_i;
            h_d  = h_i;
        end else if (en_i) begin
            if (cx_q == w_q - 8'd1) begin
                cx_d = '0;
                cy_d = cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
            w_q  <= '0;
            h_q  <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            w_q  <= w_d;
            h_q  <= h_d;
        end
    end

    assign off_x_o = cx_d;
    assign off_y_o = cy_d;
    assign last_o  = (cx_q == w_q - 8'd1) && (cy_q == h_q - 7'd1);

endmodule

// File: rtl/draw_engine.sv
// Pong draw engine: sweeps one rectangle (screen, paddle or ball) to the VGA adapter, one pixel per clock.
// Define DRAW_CLIP_EN to suppress off-screen pixels; otherwise they wrap modulo the screen size.
module draw_engine
    import draw_pkg::*;
#(
    parameter int PADDLE_H = 16,
    parameter int BALL_SZ  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] draw_state,
    input  logic [6:0] left_y,
    input  logic [6:0] right_y,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    draw_state_e state_q;
    draw_kind_e  kind_q;
    logic [8:0]  org_x_q;
    logic [7:0]  org_y_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colour_q;
    logic        plot_q, busy_q, done_q;

    rect_t       rect_d;
    logic [7:0]  off_x;
    logic [6:0]  off_y;
    logic        scan_last, pix_plot;
    logic [8:0]  cur_org_x, sum_x;
    logic [7:0]  cur_org_y, sum_y;

    always_comb begin
        rect_d = '{x: 9'd0, y: 8'd0, w: 8'(SCREEN_W), h: 7'(SCREEN_H), colour: COLOUR_BLACK};
        case (kind_q)
            DRAW_BLACK: ;
            DRAW_LEFT:  rect_d = '{x: 9'(LEFT_X), y: {1'b0, left_y}, w: 8'(PADDLE_W),
                                   h: 7'(PADDLE_H), colour: COLOUR_WHITE};
            DRAW_RIGHT: rect_d = '{x: 9'(RIGHT_X), y: {1'b0, right_y}, w: 8'(PADDLE_W),
                                   h: 7'(PADDLE_H), colour: COLOUR_WHITE};
            DRAW_BALL:  rect_d = '{x: {1'b0, ball_x}, y: {1'b0, ball_y}, w: 8'(BALL_SZ),
                                   h: 7'(BALL_SZ), colour: COLOUR_YELLOW};
            default: ;
        endcase
    end

    rect_scanner u_scanner (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (state_q == ST_LOAD),
        .en_i    ((state_q == ST_SWEEP) && !scan_last),
        .w_i     (rect_d.w),
        .h_i     (rect_d.h),
        .off_x_o (off_x),
        .off_y_o (off_y),
        .last_o  (scan_last)
    );

    // The LOAD cycle emits pixel 0 straight from the live origin; SWEEP uses the captured one.
    assign cur_org_x = (state_q == ST_LOAD) ? rect_d.x : org_x_q;
    assign cur_org_y = (state_q == ST_LOAD) ? rect_d.y : org_y_q;
    assign sum_x     = cur_org_x + {1'b0, off_x};
    assign sum_y     = cur_org_y + {1'b0, off_y};

`ifdef DRAW_CLIP_EN
    assign pix_plot = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
`else
    assign pix_plot = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            kind_q   <= DRAW_BLACK;
            org_x_q  <= '0;
            org_y_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= COLOUR_BLACK;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        kind_q  <= draw_kind_e'(draw_state);
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    org_x_q  <= rect_d.x;
                    org_y_q  <= rect_d.y;
                    colour_q <= rect_d.colour;
                    x_q      <= wrap_x(sum_x);
                    y_q      <= wrap_y(sum_y);
                    plot_q   <= pix_plot;
                    state_q  <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (scan_last) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        x_q    <= wrap_x(sum_x);
                        y_q    <= wrap_y(sum_y);
                        plot_q <= pix_plot;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: screen clear, paddles, ball wrap/clip, ignored starts and mid-job reset.
module tb_draw_engine;

    logic       clk, reset, start;
    logic [1:0] draw_state;
    logic [6:0] left_y, right_y, ball_y;
    logic [7:0] ball_x;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int checks   = 0;
    int failures = 0;

    int   px_x[$], px_y[$], px_c[$], px_cyc[$], done_cyc[$];
    logic busy_load;

    draw_engine #(.PADDLE_H(16), .BALL_SZ(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .draw_state (draw_state),
        .left_y     (left_y),
        .right_y    (right_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Window k after the start window is cycle N+k; outputs are sampled 1 time unit after each edge.
    task automatic run_job(input logic [1:0] ds, input int budget, input int restart_a,
                           input int restart_b, input int ly_at);
        int cyc;
        int stop_at;
        px_x.delete(); px_y.delete(); px_c.delete(); px_cyc.delete(); done_cyc.delete();
        busy_load  = 1'b0;
        draw_state = ds;
        start      = 1'b1;
        cyc        = 0;
        stop_at    = budget;
        while (cyc < stop_at) begin
            tick();
            cyc++;
            start = (cyc == restart_a) || (cyc == restart_b);
            if (cyc == 1) begin
                draw_state = ~ds;
                busy_load  = busy;
            end
            if (cyc == ly_at) left_y = 7'd90;
            if (plot) begin
                px_x.push_back(int'(x));
                px_y.push_back(int'(y));
                px_c.push_back(int'(colour));
                px_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                if (stop_at == budget) stop_at = cyc + 3;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({x, y, colour, plot, busy, done} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all zero",
                     x, y, colour, plot, busy, done);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got plot=%b busy=%b done=%b want 000", plot, busy, done);
        end
    endtask

    task automatic test_blank(input string tag);
        int dc;
        run_job(2'b00, 19300, -1, -1, -1);
        checks++;
        if (busy_load !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_in_load got %b want 1", tag, busy_load);
        end
        checks++;
        if (px_x.size() != 19200) begin
            failures++;
            $display("FAIL %s_pixel_count got %0d want 19200", tag, px_x.size());
        end
        for (int i = 0; i < 19200 && i < px_x.size(); i++) begin
            checks++;
            if (px_x[i] != i % 160 || px_y[i] != i / 160 || px_c[i] != 0 || px_cyc[i] != i + 2) begin
                failures++;
                $display("FAIL %s_pixel[%0d] got (%0d,%0d) c=%0d @%0d want (%0d,%0d) c=0 @%0d",
                         tag, i, px_x[i], px_y[i], px_c[i], px_cyc[i], i % 160, i / 160, i + 2);
                break;
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            failures++;
            $display("FAIL %s_done_count got %0d want 1", tag, done_cyc.size());
        end
        dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
        checks++;
        if (dc != 19202) begin
            failures++;
            $display("FAIL %s_done_cycle got %0d want 19202", tag, dc);
        end
    endtask

    // One pass with steady left_y, one with left_y changed to 90 after capture.
    task automatic test_left_paddle;
        int dc;
        for (int pass = 0; pass < 2; pass++) begin
            left_y = 7'd50;
            run_job(2'b01, 100, -1, -1, (pass == 1) ? 3 : -1);
            checks++;
            if (px_x.size() != 32) begin
                failures++;
                $display("FAIL left%0d_pixel_count got %0d want 32", pass, px_x.size());
            end
            for (int i = 0; i < 32 && i < px_x.size(); i++) begin
                checks++;
                if (px_x[i] != 4 + i % 2 || px_y[i] != 50 + i / 2 || px_c[i] != 7 || px_cyc[i] != i + 2) begin
                    failures++;
                    $display("FAIL left%0d_pixel[%0d] got (%0d,%0d) c=%0d @%0d want (%0d,%0d) c=7 @%0d",
                             pass, i, px_x[i], px_y[i], px_c[i], px_cyc[i], 4 + i % 2, 50 + i / 2, i + 2);
                    break;
                end
            end
            dc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
            checks++;
            if (dc != 34) begin
                failures++;
                $display("FAIL left%0d_single_done got count=%0d first=%0d want count=1 at 34",
                         pass, done_cyc.size(), dc);
            end
        end
    endtask

    // Extra starts land in SWEEP (cycle 5) and FIN (cycle 34); neither may spawn another job.
    task automatic test_right_ignore;
        int dc;
        right_y = 7'd10;
        run_job(2'b11, 100, 5, 34, -1);
        checks++;
        if (px_x.size() != 32) begin
            failures++;
            $display("FAIL right_pixel_count got %0d want 32", px_x.size());
        end
        for (int i = 0; i < 32 && i < px_x.size(); i++) begin
            checks++;
            if (px_x[i] != 154 + i % 2 || px_y[i] != 10 + i / 2 || px_c[i] != 7 || px_cyc[i] != i + 2) begin
                failures++;
                $display("FAIL right_pixel[%0d] got (%0d,%0d) c=%0d @%0d want (%0d,%0d) c=7 @%0d",
                         i, px_x[i], px_y[i], px_c[i], px_cyc[i], 154 + i % 2, 10 + i / 2, i + 2);
                break;
            end
        end
        dc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
        checks++;
        if (dc != 34) begin
            failures++;
            $display("FAIL right_single_done got count=%0d first=%0d want count=1 at 34", done_cyc.size(), dc);
        end
    endtask

    task automatic test_ball_edge;
        int ex[$], ey[$], ec[$];
        int dc;
        ball_x = 8'd159;
        ball_y = 7'd119;
`ifdef DRAW_CLIP_EN
        ex = '{159};
        ey = '{119};
        ec = '{2};
`else
        ex = '{159, 0, 159, 0};
        ey = '{119, 119, 0, 0};
        ec = '{2, 3, 4, 5};
`endif
        run_job(2'b10, 50, -1, -1, -1);
        checks++;
        if (px_x.size() != ex.size()) begin
            failures++;
            $display("FAIL ball_pixel_count got %0d want %0d", px_x.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < px_x.size(); i++) begin
            checks++;
            if (px_x[i] != ex[i] || px_y[i] != ey[i] || px_c[i] != 6 || px_cyc[i] != ec[i]) begin
                failures++;
                $display("FAIL ball_pixel[%0d] got (%0d,%0d) c=%0d @%0d want (%0d,%0d) c=6 @%0d",
                         i, px_x[i], px_y[i], px_c[i], px_cyc[i], ex[i], ey[i], ec[i]);
            end
        end
        dc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
        checks++;
        if (dc != 6) begin
            failures++;
            $display("FAIL ball_done got count=%0d first=%0d want count=1 at 6", done_cyc.size(), dc);
        end
    endtask

    task automatic test_reset_mid_job;
        draw_state = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (101) tick();
        checks++;
        if (plot !== 1'b1 || x !== 8'd100 || y !== 7'd0) begin
            failures++;
            $display("FAIL abort_pixel100 got plot=%b (%0d,%0d) want plot=1 (100,0)", plot, x, y);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({plot, busy, done, x, y} !== 18'd0) begin
            failures++;
            $display("FAIL abort_immediate got plot=%b busy=%b done=%b (%0d,%0d) want all zero",
                     plot, busy, done, x, y);
        end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({plot, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL abort_no_resume[%0d] got plot=%b busy=%b done=%b want 000", i, plot, busy, done);
            end
        end
    endtask

    initial begin
        start      = 1'b0;
        draw_state = 2'b00;
        left_y     = 7'd0;
        right_y    = 7'd0;
        ball_x     = 8'd0;
        ball_y     = 7'd0;
        test_reset();
        test_blank("blank");
        tick();
        test_left_paddle();
        tick();
        test_right_ignore();
        tick();
        test_ball_edge();
        tick();
        test_reset_mid_job();
        test_blank("after_abort");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_engine.md
DRAW_ENGINE -- requirements
Module: draw_engine

Interface
REQ-001 Parameter PADDLE_H, default 16, paddle height in pixels.
REQ-002 Parameter BALL_SZ, default 2, ball edge length in pixels (square).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to draw the object selected by draw_state.
REQ-006 draw_state  input  2  00 black screen, 01 left paddle, 11 right paddle, 10 ball.
REQ-007 left_y  input  7  top row of left paddle.
REQ-008 right_y  input  7  top row of right paddle.
REQ-009 ball_x  input  8  left column of ball.
REQ-010 ball_y  input  7  top row of ball.
REQ-011 x  output  8  pixel column to the VGA adapter.
REQ-012 y  output  7  pixel row to the VGA adapter.
REQ-013 colour  output  3  pixel colour, RGB.
REQ-014 plot  output  1  write strobe; x/y/colour are valid when high.
REQ-015 busy  output  1  high from the LOAD cycle through the last SWEEP cycle.
REQ-016 done  output  1  one-cycle pulse after the final pixel of a job.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SWEEP, and FIN.
- IDLE->LOAD on start=1.
- LOAD->SWEEP unconditionally.
- SWEEP->FIN after the last pixel.
- FIN->IDLE unconditionally.
REQ-018 On the start cycle, draw_state SHALL be captured; in LOAD, left_y/right_y/ball_x/ball_y SHALL be captured; input changes after capture SHALL NOT affect the job.
REQ-019 Rectangles are (origin, width x height, colour):
- 00: (0,0), 160x120, 000.
- 01: (4,left_y), 2xPADDLE_H, 111.
- 11: (154,right_y), 2xPADDLE_H, 111.
- 10: (ball_x,ball_y), BALL_SZxBALL_SZ, 110.
REQ-020 SWEEP SHALL emit exactly one pixel per clock in raster order: x increments first, then y; total cycles = width*height.
REQ-021 The first pixel SHALL appear with plot=1 two cycles after the start cycle: start at cycle N, LOAD at N+1, first pixel at N+2.
REQ-022 done SHALL be high only in FIN, for exactly one cycle; plot SHALL be 0 in IDLE, LOAD, and FIN.
REQ-023 start asserted while busy or in FIN SHALL be ignored, not queued.
REQ-024 Pixel coordinates SHALL be computed at 9-bit x / 8-bit y internally so origin+offset cannot wrap before the bounds check.
REQ-025 An invalid draw_state is impossible with 2 bits; all four codes SHALL be decoded.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, x=0, y=0, colour=000, plot=0, busy=0, done=0, and clear all counters.
REQ-027 Reset asserted mid-SWEEP SHALL abort the job with no done pulse; the next start after release SHALL begin a fresh job.

Configuration
REQ-028 With DRAW_CLIP_EN defined, pixels with x>159 or y>119 SHALL keep their cycle slot but drive plot=0.
REQ-029 Without DRAW_CLIP_EN, such pixels SHALL be plotted with x mod 160 and y mod 120 (wrap-around); cycle count is unchanged in both cases.

Structure
REQ-030 Package draw_pkg SHALL hold:
- SCREEN_W=160, SCREEN_H=120, LEFT_X=4, RIGHT_X=154, PADDLE_W=2.
- Colour constants.
- The four draw_state codes shared with the game FSM.
REQ-031 Sub-module rect_scanner SHALL implement the width/height x-y counter pair, with load, enable, and last outputs; draw_engine SHALL instantiate it once.

Verification
REQ-032 Reset release, start with draw_state=00 -> 19200 plot cycles, first pixel (0,0), last (159,119), all colour 000, done at cycle N+19202.
REQ-033 draw_state=01, left_y=50 -> 32 pixels, x in {4,5}, y 50..65, raster order, colour 111, then a single done.
REQ-034 draw_state=10, ball_x=159, ball_y=119 -> 4 SWEEP cycles.
- DRAW_CLIP_EN: only (159,119) plotted.
- Without DRAW_CLIP_EN: (159,119), (0,119), (159,0), (0,0) plotted.
REQ-035 Second start pulse during an 11 job with right_y=10 -> ignored, exactly 32 pixels, exactly one done.
REQ-036 reset pulsed low at pixel 100 of a 00 job -> plot/busy drop the same cycle, no done; a new start yields a full 19200-pixel job.
REQ-037 Change left_y from 50 to 90 at cycle N+3 of an 01 job -> pixels still y 50..65.
